branch_predict_unit: RTL and testbench

Parametrised successor to the combinational branch-condition decoder. It predicts taken or not-taken branch direction and target in IF using a direct-mapped BTB with 2-bit saturating counters. It resolves the same six MIPS conditional branches in EX from comparator flags and raises a redirect on mispredict. Counters, BTB entries and a mispredict statistic update on the clock edge after resolution.

---
 rtl/branch_predict_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_branch_predict_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped BTB with 2-bit saturating counters.
// IF-stage prediction is combinational from if_pc; EX-stage resolution of the
// six MIPS conditional branches is combinational. BTB entries, counters and
// the mispredict statistic update on the clock edge after resolution.
module branch_predict_unit #(
   parameter int unsigned PC_W  = 32,
   parameter int unsigned IDX_W = 6,
   parameter int unsigned TAG_W = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   // fetch-side lookup
   input  logic [PC_W-1:0]  if_pc,
   output logic             if_pred_taken,
   output logic [PC_W-1:0]  if_pred_target,
   // execute-side resolution
   input  logic             ex_valid,
   input  logic [PC_W-1:0]  ex_pc,
   input  logic [5:0]       ex_opcode,
   input  logic [4:0]       ex_rt,
   input  logic [PC_W-1:0]  ex_target,
   input  logic             ex_pred_taken,
   input  logic [PC_W-1:0]  ex_pred_target,
   input  logic             comp_eq,
   input  logic             comp_ltz,
   input  logic             comp_gtz,
   input  logic             comp_ez,
   output logic             ex_is_branch,
   output logic             ex_taken,
   output logic             mispredict,
   output logic [PC_W-1:0]  redirect_pc,
   output logic [CNT_W-1:0] mispredict_cnt
);

   localparam int unsigned ENTRIES = 1 << IDX_W;

   typedef enum logic [5:0] {
      OP_REGIMM = 6'b000001,
      OP_BEQ    = 6'b000100,
      OP_BNE    = 6'b000101,
      OP_BLEZ   = 6'b000110,
      OP_BGTZ   = 6'b000111
   } opcode_e;

   typedef enum logic [4:0] {
      RT_BLTZ = 5'b00000,
      RT_BGEZ = 5'b00001
   } regimm_rt_e;

   // BTB storage
   logic             valid_q  [ENTRIES];
   logic             valid_d  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [TAG_W-1:0] tag_d    [ENTRIES];
   logic [PC_W-1:0]  target_q [ENTRIES];
   logic [PC_W-1:0]  target_d [ENTRIES];
   logic [1:0]       ctr_q    [ENTRIES];
   logic [1:0]       ctr_d    [ENTRIES];

   logic [CNT_W-1:0] mispredict_cnt_q;
   logic [CNT_W-1:0] mispredict_cnt_d;

   // index / tag extraction
   logic [IDX_W-1:0] if_idx;
   logic [TAG_W-1:0] if_tag;
   logic [IDX_W-1:0] ex_idx;
   logic [TAG_W-1:0] ex_tag;
   logic             if_hit;
   logic             ex_hit;
   logic [PC_W-1:0]  if_pc_plus4;
   logic [PC_W-1:0]  ex_pc_plus4;

   // decode results (independent of ex_valid)
   logic             dec_branch;
   logic             dec_cond;

   // pc bits outside the index/tag fields are intentionally ignored
   logic             unused_pc_bits;
   assign unused_pc_bits = ^{if_pc, ex_pc};

   // address field extraction and sequential next-PC
   always_comb begin
      if_idx      = if_pc[IDX_W+1:2];
      if_tag      = if_pc[IDX_W+TAG_W+1:IDX_W+2];
      ex_idx      = ex_pc[IDX_W+1:2];
      ex_tag      = ex_pc[IDX_W+TAG_W+1:IDX_W+2];
      if_pc_plus4 = if_pc + PC_W'(4);
      ex_pc_plus4 = ex_pc + PC_W'(4);
   end

   // IF lookup: reads only registered state, so same-cycle updates are not bypassed
   always_comb begin
      if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
      if_pred_taken  = if_hit && ctr_q[if_idx][1];
      if_pred_target = if_pred_taken ? target_q[if_idx] : if_pc_plus4;
   end

   // branch-condition decode from opcode, rt and comparator flags
   always_comb begin
      dec_branch = 1'b0;
      dec_cond   = 1'b0;
      case (ex_opcode)
         OP_BEQ: begin
            dec_branch = 1'b1;
            dec_cond   = comp_eq;
         end
         OP_BNE: begin
            dec_branch = 1'b1;
            dec_cond   = !comp_eq;
         end
         OP_BLEZ: begin
            dec_branch = 1'b1;
            dec_cond   = comp_ltz | comp_ez;
         end
         OP_BGTZ: begin
            dec_branch = 1'b1;
            dec_cond   = comp_gtz;
         end
         OP_REGIMM: begin
            case (ex_rt)
               RT_BLTZ: begin
                  dec_branch = 1'b1;
                  dec_cond   = comp_ltz;
               end
               RT_BGEZ: begin
                  dec_branch = 1'b1;
                  dec_cond   = comp_gtz | comp_ez;
               end
               default: begin
                  dec_branch = 1'b0;
                  dec_cond   = 1'b0;
               end
            endcase
         end
         default: begin
            dec_branch = 1'b0;
            dec_cond   = 1'b0;
         end
      endcase
   end

   // EX resolution: all outputs forced low when the stage holds no valid instruction
   always_comb begin
      ex_is_branch = 1'b0;
      ex_taken     = 1'b0;
      mispredict   = 1'b0;
      redirect_pc  = '0;
      ex_hit       = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
      if (ex_valid) begin
         ex_is_branch = dec_branch;
         ex_taken     = dec_branch && dec_cond;
         redirect_pc  = ex_taken ? ex_target : ex_pc_plus4;
         if (dec_branch) begin
            mispredict = (ex_taken != ex_pred_taken) ||
                         (ex_taken && (ex_pred_target != ex_target));
         end else begin
            // a non-branch predicted taken is a BTB alias and must be flushed
            mispredict = ex_pred_taken;
         end
      end
   end

   // next-state for BTB entries: train on branches, drop aliased entries
   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      if (ex_valid) begin
         if (dec_branch) begin
            if (ex_hit) begin
               if (ex_taken) begin
                  if (ctr_q[ex_idx] != 2'b11) begin
                     ctr_d[ex_idx] = ctr_q[ex_idx] + 2'd1;
                  end
                  target_d[ex_idx] = ex_target;
               end else if (ctr_q[ex_idx] != 2'b00) begin
                  ctr_d[ex_idx] = ctr_q[ex_idx] - 2'd1;
               end
            end else if (ex_taken) begin
               valid_d[ex_idx]  = 1'b1;
               tag_d[ex_idx]    = ex_tag;
               target_d[ex_idx] = ex_target;
               ctr_d[ex_idx]    = 2'b10;
            end
         end else if (ex_pred_taken && ex_hit) begin
            valid_d[ex_idx] = 1'b0;
         end
      end
   end

   // saturating mispredict statistic
   always_comb begin
      mispredict_cnt_d = mispredict_cnt_q;
      if (mispredict && (mispredict_cnt_q != '1)) begin
         mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
      end
   end

   assign mispredict_cnt = mispredict_cnt_q;

   // state registers; asynchronous reset overrides any pending update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'b01;
         end
         mispredict_cnt_q <= '0;
      end else begin
         valid_q          <= valid_d;
         tag_q            <= tag_d;
         target_q         <= target_d;
         ctr_q            <= ctr_d;
         mispredict_cnt_q <= mispredict_cnt_d;
      end
   end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: a vector table driven through a
// scoreboard queue, plus hand sequences for counter saturation and mid-update reset.
module tb_branch_predict_unit;

   localparam int CW = 4;

   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;
   localparam logic [5:0] OP_LW     = 6'b100011;

   // flags: {eq, ltz, gtz, ez}
   localparam logic [3:0] F_EQ  = 4'b1000;
   localparam logic [3:0] F_LTZ = 4'b0100;
   localparam logic [3:0] F_GTZ = 4'b0010;
   localparam logic [3:0] F_EZ  = 4'b0001;

   localparam logic [31:0] A  = 32'h0040_0010, A4 = 32'h0040_0014, B  = 32'h0040_0100;
   localparam logic [31:0] C  = 32'h0040_0200, C4 = 32'h0040_0204, D  = 32'h0040_0300;
   localparam logic [31:0] E  = 32'h0040_0020, E4 = 32'h0040_0024, ET = 32'h0040_0080;
   localparam logic [31:0] F  = 32'h0040_0040, F4 = 32'h0040_0044, FT = 32'h0040_0400;
   localparam logic [31:0] G  = 32'h0040_0060, G4 = 32'h0040_0064, GT = 32'h0040_0160;
   localparam logic [31:0] EA = 32'h0040_1020, EA4 = 32'h0040_1024;

   typedef struct {
      logic [31:0]   if_pc;
      logic          ex_valid;
      logic [31:0]   ex_pc;
      logic [5:0]    op;
      logic [4:0]    rt;
      logic [31:0]   tgt;
      logic          pt;
      logic [31:0]   ptgt;
      logic [3:0]    flags;
      logic          e_pt;
      logic [31:0]   e_ptgt;
      logic          e_isb;
      logic          e_tk;
      logic          e_mp;
      logic [31:0]   e_rpc;
      logic [CW-1:0] e_cnt;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [31:0]   if_pc;
   logic          if_pred_taken;
   logic [31:0]   if_pred_target;
   logic          ex_valid;
   logic [31:0]   ex_pc;
   logic [5:0]    ex_opcode;
   logic [4:0]    ex_rt;
   logic [31:0]   ex_target;
   logic          ex_pred_taken;
   logic [31:0]   ex_pred_target;
   logic          comp_eq, comp_ltz, comp_gtz, comp_ez;
   logic          ex_is_branch;
   logic          ex_taken;
   logic          mispredict;
   logic [31:0]   redirect_pc;
   logic [CW-1:0] mispredict_cnt;

   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t exp_q[$];
   vec_t vecs[21];

   branch_predict_unit #(
      .PC_W (32),
      .IDX_W(6),
      .TAG_W(8),
      .CNT_W(CW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .if_pc         (if_pc),
      .if_pred_taken (if_pred_taken),
      .if_pred_target(if_pred_target),
      .ex_valid      (ex_valid),
      .ex_pc         (ex_pc),
      .ex_opcode     (ex_opcode),
      .ex_rt         (ex_rt),
      .ex_target     (ex_target),
      .ex_pred_taken (ex_pred_taken),
      .ex_pred_target(ex_pred_target),
      .comp_eq       (comp_eq),
      .comp_ltz      (comp_ltz),
      .comp_gtz      (comp_gtz),
      .comp_ez       (comp_ez),
      .ex_is_branch  (ex_is_branch),
      .ex_taken      (ex_taken),
      .mispredict    (mispredict),
      .redirect_pc   (redirect_pc),
      .mispredict_cnt(mispredict_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   function automatic vec_t mk(
      input logic [31:0] ipc, input logic v, input logic [31:0] epc,
      input logic [5:0] op, input logic [4:0] rt, input logic [31:0] tgt,
      input logic pt, input logic [31:0] ptgt, input logic [3:0] fl,
      input logic e_pt, input logic [31:0] e_ptgt, input logic e_isb,
      input logic e_tk, input logic e_mp, input logic [31:0] e_rpc,
      input logic [CW-1:0] e_cnt);
      vec_t r;
      r.if_pc = ipc;  r.ex_valid = v;  r.ex_pc = epc;  r.op = op;  r.rt = rt;
      r.tgt = tgt;  r.pt = pt;  r.ptgt = ptgt;  r.flags = fl;
      r.e_pt = e_pt;  r.e_ptgt = e_ptgt;  r.e_isb = e_isb;  r.e_tk = e_tk;
      r.e_mp = e_mp;  r.e_rpc = e_rpc;  r.e_cnt = e_cnt;
      return r;
   endfunction

   task automatic chk(input string nm, input int id, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %h expected %h", nm, id, act, exp);
      end
   endtask

   // drive inputs and push the matching expectation onto the scoreboard
   task automatic drive(input vec_t v);
      if_pc          = v.if_pc;
      ex_valid       = v.ex_valid;
      ex_pc          = v.ex_pc;
      ex_opcode      = v.op;
      ex_rt          = v.rt;
      ex_target      = v.tgt;
      ex_pred_taken  = v.pt;
      ex_pred_target = v.ptgt;
      {comp_eq, comp_ltz, comp_gtz, comp_ez} = v.flags;
      exp_q.push_back(v);
   endtask

   // pop the oldest expectation and compare against the DUT outputs
   task automatic sample(input int id);
      vec_t e;
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard[%0d]: got empty queue expected entry", id);
      end else begin
         e = exp_q.pop_front();
         chk("if_pred_taken",  id, 32'(if_pred_taken),  32'(e.e_pt));
         chk("if_pred_target", id, if_pred_target,      e.e_ptgt);
         chk("ex_is_branch",   id, 32'(ex_is_branch),   32'(e.e_isb));
         chk("ex_taken",       id, 32'(ex_taken),       32'(e.e_tk));
         chk("mispredict",     id, 32'(mispredict),     32'(e.e_mp));
         chk("redirect_pc",    id, redirect_pc,         e.e_rpc);
         chk("mispredict_cnt", id, 32'(mispredict_cnt), 32'(e.e_cnt));
      end
   endtask

   task automatic run_vec(input vec_t v, input int id);
      @(posedge clk);
      #1;
      drive(v);
      @(negedge clk);
      sample(id);
   endtask

   initial begin
      int unsigned cnt_m;
      vec_t v;

      // expected results; each row is sampled before the edge that applies its update
      vecs[0]  = mk(A, 0, 0, 0, 0, 0, 0, 0, 0,            0, A4, 0, 0, 0, 0,  0);
      vecs[1]  = mk(A, 1, A, OP_BEQ, 0, B, 0, A4, F_EQ,   0, A4, 1, 1, 1, B,  0);
      vecs[2]  = mk(A, 1, A, OP_BEQ, 0, B, 1, B, F_EQ,    1, B,  1, 1, 0, B,  1);
      vecs[3]  = mk(A, 1, A, OP_BEQ, 0, B, 1, B, F_EQ,    1, B,  1, 1, 0, B,  1);
      vecs[4]  = mk(A, 1, A, OP_BEQ, 0, B, 1, B, 0,       1, B,  1, 0, 1, A4, 1);
      vecs[5]  = mk(A, 0, 0, 0, 0, 0, 0, 0, 0,            1, B,  0, 0, 0, 0,  2);
      vecs[6]  = mk(A, 1, A, OP_BEQ, 0, B, 1, B, 0,       1, B,  1, 0, 1, A4, 2);
      vecs[7]  = mk(A, 0, 0, 0, 0, 0, 0, 0, 0,            0, A4, 0, 0, 0, 0,  3);
      vecs[8]  = mk(C, 1, C, OP_REGIMM, 1, D, 0, C4, F_EZ, 0, C4, 1, 1, 1, D, 3);
      vecs[9]  = mk(C, 1, C, OP_REGIMM, 2, D, 0, C4, F_EZ, 1, D, 0, 0, 0, C4, 4);
      vecs[10] = mk(C, 1, C, OP_LW, 0, D, 1, D, 0,        1, D,  0, 0, 1, C4, 4);
      vecs[11] = mk(C, 0, 0, 0, 0, 0, 0, 0, 0,            0, C4, 0, 0, 0, 0,  5);
      vecs[12] = mk(E, 1, E, OP_BNE, 0, ET, 0, E4, 0,     0, E4, 1, 1, 1, ET, 5);
      vecs[13] = mk(EA, 0, 0, 0, 0, 0, 0, 0, 0,           0, EA4, 0, 0, 0, 0, 6);
      vecs[14] = mk(E, 0, 0, 0, 0, 0, 0, 0, 0,            1, ET, 0, 0, 0, 0,  6);
      vecs[15] = mk(E, 1, E, OP_BNE, 0, ET, 1, 32'h0040_0090, 0, 1, ET, 1, 1, 1, ET, 6);
      vecs[16] = mk(F, 1, F, OP_BLEZ, 0, FT, 0, F4, F_LTZ, 0, F4, 1, 1, 1, FT, 7);
      vecs[17] = mk(F, 1, F, OP_BGTZ, 0, FT, 1, FT, F_EZ, 1, FT, 1, 0, 1, F4, 8);
      vecs[18] = mk(F, 1, F, OP_REGIMM, 0, FT, 0, F4, F_GTZ, 0, F4, 1, 0, 0, F4, 9);
      vecs[19] = mk(G, 0, G, OP_BEQ, 0, GT, 0, G4, F_EQ,  0, G4, 0, 0, 0, 0,  9);
      vecs[20] = mk(G, 0, 0, 0, 0, 0, 0, 0, 0,            0, G4, 0, 0, 0, 0,  9);

      // reset, with a lookup checked while reset is held
      rst_n = 1'b0;
      v = mk(A, 0, 0, 0, 0, 0, 0, 0, 0, 0, A4, 0, 0, 0, 0, 0);
      drive(v);
      @(negedge clk);
      sample(100);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < 21; i++) begin
         run_vec(vecs[i], i);
      end

      // statistic saturation: aliased non-branches at a missing PC keep mispredicting
      cnt_m = 9;
      for (int k = 0; k < 9; k++) begin
         v = mk(G, 1, G, OP_LW, 0, 0, 1, G4, 0, 0, G4, 0, 0, 1, G4, CW'(cnt_m));
         run_vec(v, 200 + k);
         if (cnt_m < (1 << CW) - 1) cnt_m++;
      end
      v = mk(G, 0, 0, 0, 0, 0, 0, 0, 0, 0, G4, 0, 0, 0, 0, CW'(cnt_m));
      run_vec(v, 209);

      // reset asserted while a taken branch update is pending at G
      v = mk(E, 1, G, OP_BEQ, 0, GT, 0, G4, F_EQ, 1, ET, 1, 1, 1, GT, CW'(cnt_m));
      run_vec(v, 300);
      #2;
      rst_n = 1'b0;
      #1;
      v = mk(E, 1, G, OP_BEQ, 0, GT, 0, G4, F_EQ, 0, E4, 1, 1, 1, GT, 0);
      drive(v);
      sample(301);
      @(negedge clk);
      drive(v);
      sample(302);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      v = mk(G, 0, 0, 0, 0, 0, 0, 0, 0, 0, G4, 0, 0, 0, 0, 0);
      drive(v);
      @(negedge clk);
      sample(303);
      v = mk(A, 0, 0, 0, 0, 0, 0, 0, 0, 0, A4, 0, 0, 0, 0, 0);
      run_vec(v, 304);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
